zacore_hazard_scoreboard: RTL and testbench
===========================================

// Module: zacore_hazard_scoreboard
// PURPOSE
//  Issue controller for the decode stage: tracks in-flight register writes and decides each cycle
//  whether the instruction held in decode may issue to execute. Sits beside zacore_decode; drives
//  the decode stall toward fetch and the issue strobe into the decode->execute flop stage.
//  Retires writes reported by writeback. Sequences recovery after an invalidate/flush.
// PARAMETERS
//  NUM_REGS  32  architectural integer registers; x0 is never tracked
//  CNT_W     2   per-register pending-write counter width; max 2**CNT_W-1 outstanding writes per reg
// PORTS
//  i_clk        in   1        clock
//  i_rst        in   1        reset; asynchronous, active-high
//  i_req_valid  in   1        decode holds a valid instruction
//  i_rs1        in   5        source register 1 index
//  i_rs1_used   in   1        instruction reads rs1 (from inst_type)
//  i_rs2        in   5        source register 2 index
//  i_rs2_used   in   1        instruction reads rs2
//  i_rd         in   5        destination index
//  i_rd_we      in   1        instruction writes rd
//  i_stall      in   1        execute cannot accept; blocks issue
//  i_invalidate in   1        flush request from execute (branch/jump redirect)
//  i_wb_valid   in   1        writeback retiring an instruction with rd_we=1 this cycle
//  i_wb_rd      in   5        destination being retired
//  o_issue      out  1        instruction issues this cycle (decode->execute flop loads)
//  o_stall      out  1        stall to fetch/decode: hold current instruction
//  o_draining   out  1        FSM in DRAIN
//  o_outstanding out OUT_W    total pending writes, OUT_W=$clog2(NUM_REGS*(2**CNT_W-1)+1)
// BEHAVIOUR
//  - Reset (async): all counters 0, total 0, state RUN; o_issue=0, o_stall=0, o_draining=0, o_outstanding=0.
//  - hazard = i_rsN_used && rsN!=0 && cnt[rsN]!=0 (either source); waw_full = i_rd_we && rd!=0 && cnt[rd]==max.
//  - RUN: o_issue = i_req_valid && !hazard && !waw_full && !i_stall && !i_invalidate (combinational).
//    o_stall = i_req_valid && !o_issue. Zero-latency decision; counter update visible next cycle.
//  - On o_issue with i_rd_we && rd!=0: cnt[rd]++ and total++ at clock edge.
//  - On i_wb_valid with wb_rd!=0: cnt[wb_rd]-- and total--. Retire with cnt==0: counter stays 0,
//    simulation assertion fires (protocol error). wb_rd==0 ignored.
//  - Same-cycle issue and retire to same reg: counter unchanged; total unchanged.
//  - Issue and retire to different regs: both applied independently.
//  - i_invalidate (any state): o_issue forced 0 that cycle; next state DRAIN. Squashed in-flight
//    instructions still retire via writeback (write suppressed downstream), so counters stay exact.
//  - DRAIN: o_issue=0, o_stall=i_req_valid, o_draining=1; retires continue. Leave to RUN the cycle
//    after total==0 (total==0 on entry → exactly 1 cycle in DRAIN). Further invalidate re-enters DRAIN.
//  - States: RUN --invalidate--> DRAIN --(total==0 && !invalidate)--> RUN.
//  - Counter arithmetic is unsigned, never wraps: increments blocked by waw_full, decrements clamped at 0.
// CONFIGURATION
//  ZACORE_SCOREBOARD_BYPASS_EN defined: a same-cycle retire of rsN with cnt[rsN]==1 clears that
//    hazard combinationally (register file write-through into decode); issue may occur that cycle.
//  Not defined: hazard clears only the cycle after the counter reaches 0 (one extra bubble).
// STRUCTURE
//  zacore_common: reg_idx_t (logic [4:0]), scoreboard_state_t enum {SB_RUN, SB_DRAIN},
//    sb_req_t struct (valid, rs1, rs1_used, rs2, rs2_used, rd, rd_we).
//  Sub-module zacore_pending_counter (one per tracked reg, x1..x31): inc/dec inputs, count, zero, full.
//  Top holds FSM, total counter, hazard/issue logic.
// TESTING
//  1 Issue ADDI x5 (rd_we); next cycle ADD x6,x5,x1 -> o_stall=1, o_issue=0 until wb_rd=5 retires;
//    issues cycle after retire (no BYPASS) / same cycle as retire (BYPASS).
//  2 Three issues writing x7 (CNT_W=2) then a 4th writing x7 -> 4th stalls (waw_full) until one retire.
//  3 Issue and retire x9 same cycle with cnt[9]=1 -> cnt[9] stays 1, o_outstanding unchanged.
//  4 o_outstanding=3, assert i_invalidate -> o_issue=0, DRAIN; three retires -> RUN next cycle, issue resumes.
//  5 Reads/writes of x0 with i_wb_rd=0 -> never stall, counters and o_outstanding remain 0.
//  6 Assert i_rst mid-DRAIN with counters nonzero -> immediately all outputs 0, state RUN, counters 0.

Source files
------------

// File: rtl/zacore_common_pkg.sv
// Shared types for the zacore decode/issue slice: register index, scoreboard
// FSM states, the decode request bundle, and the outstanding-count width helper.
package zacore_common_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    SB_RUN,
    SB_DRAIN
  } scoreboard_state_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    logic     rs1_used;
    reg_idx_t rs2;
    logic     rs2_used;
    reg_idx_t rd;
    logic     rd_we;
  } sb_req_t;

  // Width needed to count every tracked register at its maximum pending count.
  function automatic int sb_out_w(input int num_regs, input int cnt_w);
    return $clog2(num_regs * ((1 << cnt_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/zacore_pending_counter.sv
// Pending-write counter for one architectural register. Saturating in both
// directions: increments are ignored when full, decrements are ignored at zero
// (the latter is a writeback protocol error and is flagged by an assertion).
module zacore_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero,
  output logic             o_full
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_count = cnt_q;
  assign o_zero  = (cnt_q == '0);
  assign o_full  = (cnt_q == '1);

  // Next count: a simultaneous inc and dec cancel out.
  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (i_inc && !i_dec && !o_full) begin
      cnt_d = cnt_q + 1'b1;
    end else if (i_dec && !i_inc && !o_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A retire with nothing pending means writeback and issue disagree.
  retire_underflow_a : assert property (
    @(posedge i_clk) disable iff (i_rst) !(i_dec && !i_inc && o_zero)
  ) else $error("zacore_pending_counter: retire with no pending write");

endmodule

// File: rtl/zacore_hazard_scoreboard.sv
// Decode-stage issue controller. Tracks pending register writes per register
// (x1..x31), decides issue/stall combinationally each cycle, and runs a
// RUN/DRAIN FSM that holds issue after an invalidate until all in-flight
// writes have retired.
// Optional feature: define ZACORE_SCOREBOARD_BYPASS_EN to let a same-cycle
// retire of a source register's last pending write clear its hazard.
module zacore_hazard_scoreboard
  import zacore_common_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int CNT_W    = 2,
  localparam int OUT_W    = sb_out_w(NUM_REGS, CNT_W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  input  reg_idx_t         i_rs1,
  input  logic             i_rs1_used,
  input  reg_idx_t         i_rs2,
  input  logic             i_rs2_used,
  input  reg_idx_t         i_rd,
  input  logic             i_rd_we,
  input  logic             i_stall,
  input  logic             i_invalidate,
  input  logic             i_wb_valid,
  input  reg_idx_t         i_wb_rd,
  output logic             o_issue,
  output logic             o_stall,
  output logic             o_draining,
  output logic [OUT_W-1:0] o_outstanding
);

  sb_req_t req;

  assign req = '{valid:    i_req_valid,
                 rs1:      i_rs1,
                 rs1_used: i_rs1_used,
                 rs2:      i_rs2,
                 rs2_used: i_rs2_used,
                 rd:       i_rd,
                 rd_we:    i_rd_we};

  // ---------------------------------------------------------------------------
  // Per-register pending counters (x0 is hardwired to "nothing pending")
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] zero_v;
  logic [NUM_REGS-1:0] full_v;
  logic                do_write;
  logic                do_retire;

  assign cnt[0]    = '0;
  assign zero_v[0] = 1'b1;
  assign full_v[0] = 1'b0;

  assign do_write  = o_issue && req.rd_we && (req.rd != '0);
  assign do_retire = i_wb_valid && (i_wb_rd != '0);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    zacore_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (do_write  && (req.rd  == REG_IDX_W'(r))),
      .i_dec   (do_retire && (i_wb_rd == REG_IDX_W'(r))),
      .o_count (cnt[r]),
      .o_zero  (zero_v[r]),
      .o_full  (full_v[r])
    );
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic rs1_haz;
  logic rs2_haz;
  logic waw_full;
  logic can_issue;

  // RAW hazard per source; with bypass, the retiring last write forwards through.
  always_comb begin
    rs1_haz = req.rs1_used && (req.rs1 != '0) && !zero_v[req.rs1];
    rs2_haz = req.rs2_used && (req.rs2 != '0) && !zero_v[req.rs2];
`ifdef ZACORE_SCOREBOARD_BYPASS_EN
    if (i_wb_valid && (i_wb_rd == req.rs1) && (cnt[req.rs1] == CNT_W'(1))) begin
      rs1_haz = 1'b0;
    end
    if (i_wb_valid && (i_wb_rd == req.rs2) && (cnt[req.rs2] == CNT_W'(1))) begin
      rs2_haz = 1'b0;
    end
`endif
  end

  assign waw_full  = req.rd_we && (req.rd != '0) && full_v[req.rd];
  assign can_issue = req.valid && !rs1_haz && !rs2_haz && !waw_full && !i_stall && !i_invalidate;

  // ---------------------------------------------------------------------------
  // Total outstanding writes
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] total_q;
  logic [OUT_W-1:0] total_d;
  logic             retire_eff;

  // A retire only counts if it actually removes a pending write (or cancels a same-cycle issue).
  assign retire_eff = do_retire &&
                      (!zero_v[i_wb_rd] || (do_write && (req.rd == i_wb_rd)));
  assign total_d    = total_q + OUT_W'(do_write) - OUT_W'(retire_eff);

  // Total counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign o_outstanding = total_q;

  // ---------------------------------------------------------------------------
  // RUN/DRAIN FSM
  // ---------------------------------------------------------------------------
  scoreboard_state_t state_q;
  scoreboard_state_t state_d;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: invalidate always (re)enters DRAIN; DRAIN exits once nothing is pending.
  always_comb begin
    state_d = state_q;
    if (i_invalidate) begin
      state_d = SB_DRAIN;
    end else if ((state_q == SB_DRAIN) && (total_q == '0)) begin
      state_d = SB_RUN;
    end
  end

  // Outputs: RUN issues when clear; DRAIN holds whatever decode presents.
  always_comb begin
    o_issue    = 1'b0;
    o_stall    = 1'b0;
    o_draining = 1'b0;
    case (state_q)
      SB_RUN: begin
        o_issue = can_issue;
        o_stall = req.valid && !can_issue;
      end
      SB_DRAIN: begin
        o_stall    = req.valid;
        o_draining = 1'b1;
      end
      default: begin
        o_stall = req.valid;
      end
    endcase
  end

endmodule

// File: tb/tb_zacore_hazard_scoreboard.sv
// Directed bench for zacore_hazard_scoreboard. Inputs change just after the
// falling edge; outputs are compared 1 ns later, well before the rising edge.
module tb_zacore_hazard_scoreboard;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req_valid;
  logic [4:0] i_rs1;
  logic       i_rs1_used;
  logic [4:0] i_rs2;
  logic       i_rs2_used;
  logic [4:0] i_rd;
  logic       i_rd_we;
  logic       i_stall;
  logic       i_invalidate;
  logic       i_wb_valid;
  logic [4:0] i_wb_rd;
  logic       o_issue;
  logic       o_stall;
  logic       o_draining;
  logic [6:0] o_outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  zacore_hazard_scoreboard dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .i_rs1         (i_rs1),
    .i_rs1_used    (i_rs1_used),
    .i_rs2         (i_rs2),
    .i_rs2_used    (i_rs2_used),
    .i_rd          (i_rd),
    .i_rd_we       (i_rd_we),
    .i_stall       (i_stall),
    .i_invalidate  (i_invalidate),
    .i_wb_valid    (i_wb_valid),
    .i_wb_rd       (i_wb_rd),
    .o_issue       (o_issue),
    .o_stall       (o_stall),
    .o_draining    (o_draining),
    .o_outstanding (o_outstanding)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_req_valid  = 1'b0;
    i_rs1        = '0;
    i_rs1_used   = 1'b0;
    i_rs2        = '0;
    i_rs2_used   = 1'b0;
    i_rd         = '0;
    i_rd_we      = 1'b0;
    i_stall      = 1'b0;
    i_invalidate = 1'b0;
    i_wb_valid   = 1'b0;
    i_wb_rd      = '0;
  endtask

  // Next cycle: wait for the falling edge and clear all requests.
  task automatic tick();
    @(negedge i_clk);
    idle();
  endtask

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we);
    i_req_valid = 1'b1;
    i_rs1       = rs1;
    i_rs1_used  = u1;
    i_rs2       = rs2;
    i_rs2_used  = u2;
    i_rd        = rd;
    i_rd_we     = we;
  endtask

  task automatic retire(input logic [4:0] rd);
    i_wb_valid = 1'b1;
    i_wb_rd    = rd;
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    #1;
    check("rst_issue", o_issue, 0);
    check("rst_stall", o_stall, 0);
    check("rst_draining", o_draining, 0);
    check("rst_outstanding", o_outstanding, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // 1: ADDI x5 then dependent ADD x6,x5,x1
    tick(); drive(5'd1, 1, 5'd0, 0, 5'd5, 1); #1;
    check("t1_addi_issue", o_issue, 1);
    check("t1_addi_stall", o_stall, 0);
    tick(); drive(5'd5, 1, 5'd1, 1, 5'd6, 1); #1;
    check("t1_raw_issue", o_issue, 0);
    check("t1_raw_stall", o_stall, 1);
    check("t1_raw_outstanding", o_outstanding, 1);
    tick(); drive(5'd5, 1, 5'd1, 1, 5'd6, 1); retire(5'd5); #1;
    check("t1_retire_outstanding", o_outstanding, 1);
`ifdef ZACORE_SCOREBOARD_BYPASS_EN
    check("t1_retire_issue", o_issue, 1);
    check("t1_retire_stall", o_stall, 0);
`else
    check("t1_retire_issue", o_issue, 0);
    check("t1_retire_stall", o_stall, 1);
    tick(); drive(5'd5, 1, 5'd1, 1, 5'd6, 1); #1;
    check("t1_after_issue", o_issue, 1);
    check("t1_after_outstanding", o_outstanding, 0);
`endif
    tick(); #1;
    check("t1_x6_pending", o_outstanding, 1);
    tick(); retire(5'd6);
    tick(); #1;
    check("t1_clean", o_outstanding, 0);

    // 2: three writes to x7 fill its counter; the fourth waits for a retire
    for (int k = 0; k < 3; k++) begin
      tick(); drive(5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
      check($sformatf("t2_issue%0d", k), o_issue, 1);
      check($sformatf("t2_outstanding%0d", k), o_outstanding, k);
    end
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
    check("t2_full_issue", o_issue, 0);
    check("t2_full_stall", o_stall, 1);
    check("t2_full_outstanding", o_outstanding, 3);
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd7, 1); retire(5'd7); #1;
    check("t2_full_retire_issue", o_issue, 0);
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
    check("t2_unblock_issue", o_issue, 1);
    check("t2_unblock_outstanding", o_outstanding, 2);

    // 4: invalidate with three outstanding, drain via retires
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd8, 0); i_invalidate = 1'b1; #1;
    check("t4_inv_outstanding", o_outstanding, 3);
    check("t4_inv_issue", o_issue, 0);
    check("t4_inv_stall", o_stall, 1);
    check("t4_inv_draining", o_draining, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); drive(5'd0, 0, 5'd0, 0, 5'd8, 0); retire(5'd7); #1;
      check($sformatf("t4_drain_flag%0d", k), o_draining, 1);
      check($sformatf("t4_drain_issue%0d", k), o_issue, 0);
      check($sformatf("t4_drain_outstanding%0d", k), o_outstanding, 3 - k);
    end
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd8, 0); #1;
    check("t4_last_drain_flag", o_draining, 1);
    check("t4_last_drain_stall", o_stall, 1);
    check("t4_last_drain_outstanding", o_outstanding, 0);
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd8, 0); #1;
    check("t4_run_draining", o_draining, 0);
    check("t4_run_issue", o_issue, 1);

    // 3: same-cycle issue and retire of x9 with one pending
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd9, 1); #1;
    check("t3_first_issue", o_issue, 1);
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd9, 1); retire(5'd9); #1;
    check("t3_pair_issue", o_issue, 1);
    check("t3_pair_outstanding", o_outstanding, 1);
    tick(); drive(5'd9, 1, 5'd0, 0, 5'd10, 0); #1;
    check("t3_after_outstanding", o_outstanding, 1);
    check("t3_x9_still_pending", o_issue, 0);
    tick(); retire(5'd9);
    tick(); #1;
    check("t3_clean", o_outstanding, 0);

    // 5: x0 is never tracked
    tick(); drive(5'd0, 1, 5'd0, 1, 5'd0, 1); retire(5'd0); #1;
    check("t5_issue0", o_issue, 1);
    check("t5_stall0", o_stall, 0);
    tick(); drive(5'd0, 1, 5'd0, 1, 5'd0, 1); #1;
    check("t5_issue1", o_issue, 1);
    check("t5_outstanding1", o_outstanding, 0);
    tick(); #1;
    check("t5_outstanding2", o_outstanding, 0);

    // 6: reset asserted mid-DRAIN clears everything immediately
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd3, 1);
    tick(); drive(5'd0, 0, 5'd0, 0, 5'd4, 1);
    tick(); i_invalidate = 1'b1;
    tick(); #1;
    check("t6_pre_draining", o_draining, 1);
    check("t6_pre_outstanding", o_outstanding, 2);
    #1 i_rst = 1'b1;
    #1;
    check("t6_rst_draining", o_draining, 0);
    check("t6_rst_outstanding", o_outstanding, 0);
    check("t6_rst_issue", o_issue, 0);
    check("t6_rst_stall", o_stall, 0);
    tick(); i_rst = 1'b0; drive(5'd3, 1, 5'd4, 1, 5'd11, 0); #1;
    check("t6_post_issue", o_issue, 1);
    check("t6_post_draining", o_draining, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
